// File: rtl/chime_ctrl.sv
// chime_ctrl: beep scheduler feeding the count_buzz stage.
// It produces an hourly chime, with one beep per hour on a 12-hour dial,
// and a snoozable alarm that stops by itself after a timeout.
module chime_ctrl #(
  parameter int SNOOZE_SEC        = 300,
  parameter int ALARM_TIMEOUT_SEC = 60,
  parameter bit CHIME_EN          = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sec_tick,
  input  logic [4:0] hour,
  input  logic [5:0] minute,
  input  logic [5:0] second,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  input  logic       alarm_on,
  input  logic       stop_key,
  input  logic       snooze_key,
  input  logic       beep_done,
  output logic       buzz_en,
  output logic [3:0] beep_count,
  output logic       alarm_active,
  output logic       chime_active
);

  // The seconds counter is shared by SNOOZE and ALARM. It is sized so the
  // larger limit can be reached without the counter wrapping.
  localparam int SEC_MAX = (SNOOZE_SEC > ALARM_TIMEOUT_SEC) ? SNOOZE_SEC : ALARM_TIMEOUT_SEC;
  localparam int SEC_W   = (SEC_MAX < 1) ? 1 : $clog2(SEC_MAX + 1);
  localparam logic [SEC_W-1:0] SNZ_LIM = SEC_W'(SNOOZE_SEC);
  localparam logic [SEC_W-1:0] TMO_LIM = SEC_W'(ALARM_TIMEOUT_SEC);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CHIME  = 2'd1,
    ST_ALARM  = 2'd2,
    ST_SNOOZE = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [3:0]       beep_count_nxt;
  logic [3:0]       beep_cnt, beep_cnt_nxt;
  logic [SEC_W-1:0] sec_cnt, sec_cnt_nxt;
  logic [4:0]       h_mod;
  logic             alarm_trig, chime_trig;

  // Both triggers are qualified by sec_tick, so each match fires once.
  always_comb begin
    alarm_trig = sec_tick && alarm_on && (hour == alarm_hour) &&
                 (minute == alarm_min) && (second == 6'd0);
    chime_trig = sec_tick && CHIME_EN && (minute == 6'd0) && (second == 6'd0);
    h_mod      = (hour >= 5'd12) ? (hour - 5'd12) : hour;
  end

  // Next-state logic. Keys and disarm are evaluated before triggers and
  // timeouts, so a key pulse that coincides with sec_tick wins.
  always_comb begin
    state_nxt      = state;
    beep_count_nxt = beep_count;
    beep_cnt_nxt   = beep_cnt;
    sec_cnt_nxt    = sec_cnt;
    case (state)
      ST_IDLE: begin
        if (alarm_trig) begin
          state_nxt      = ST_ALARM;
          beep_count_nxt = 4'd15;
          sec_cnt_nxt    = '0;
          beep_cnt_nxt   = '0;
        end else if (chime_trig) begin
          state_nxt      = ST_CHIME;
          beep_count_nxt = (h_mod == 5'd0) ? 4'd12 : h_mod[3:0];
          beep_cnt_nxt   = '0;
        end
      end
      ST_CHIME: begin
        if (stop_key) begin
          state_nxt = ST_IDLE;
        end else if (alarm_trig) begin
          state_nxt      = ST_ALARM;
          beep_count_nxt = 4'd15;
          sec_cnt_nxt    = '0;
          beep_cnt_nxt   = '0;
        end else if (beep_done) begin
          beep_cnt_nxt = beep_cnt + 4'd1;
          // Leave on the last beep_done so buzz_en never opens another beep.
          if ((beep_cnt + 4'd1) == beep_count) state_nxt = ST_IDLE;
        end
      end
      ST_ALARM: begin
        if (!alarm_on || stop_key) begin
          state_nxt = ST_IDLE;
        end else if (snooze_key) begin
          state_nxt   = ST_SNOOZE;
          sec_cnt_nxt = '0;
        end else if (sec_tick) begin
          sec_cnt_nxt = sec_cnt + SEC_W'(1);
          if ((sec_cnt + SEC_W'(1)) == TMO_LIM) state_nxt = ST_IDLE;
        end
      end
      ST_SNOOZE: begin
        if (!alarm_on || stop_key) begin
          state_nxt = ST_IDLE;
        end else if (sec_tick) begin
          sec_cnt_nxt = sec_cnt + SEC_W'(1);
          if ((sec_cnt + SEC_W'(1)) == SNZ_LIM) begin
            state_nxt      = ST_ALARM;
            beep_count_nxt = 4'd15;
            sec_cnt_nxt    = '0;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and counter registers, which clear asynchronously on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      beep_count <= '0;
      beep_cnt   <= '0;
      sec_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      beep_count <= beep_count_nxt;
      beep_cnt   <= beep_cnt_nxt;
      sec_cnt    <= sec_cnt_nxt;
    end
  end

  // Outputs are decoded from the registered state only.
  always_comb begin
    buzz_en      = (state == ST_CHIME) || (state == ST_ALARM);
    chime_active = (state == ST_CHIME);
    alarm_active = (state == ST_ALARM) || (state == ST_SNOOZE);
  end

endmodule
